mem_access_stage: RTL

//  Memory-access stage directly downstream of the execute stage (via the exe/mem pipeline register).

---
 rtl/mem_access_stage_pkg.sv | 44 ++++
 rtl/mem_lane_unit.sv | 54 +++++
 rtl/mem_access_stage.sv | 167 ++++++++++++++++
 3 files changed

// File: rtl/mem_access_stage_pkg.sv
// Shared opcodes, exception codes and state encoding for the memory-access stage.
package mem_access_stage_pkg;

    localparam logic [7:0] MINIMIPS32_ADDU = 8'h19;
    localparam logic [7:0] MINIMIPS32_MTHI = 8'h13;
    localparam logic [7:0] MINIMIPS32_LB   = 8'h90;
    localparam logic [7:0] MINIMIPS32_LBU  = 8'h91;
    localparam logic [7:0] MINIMIPS32_LH   = 8'h92;
    localparam logic [7:0] MINIMIPS32_LHU  = 8'h93;
    localparam logic [7:0] MINIMIPS32_LW   = 8'h94;
    localparam logic [7:0] MINIMIPS32_SB   = 8'h98;
    localparam logic [7:0] MINIMIPS32_SH   = 8'h99;
    localparam logic [7:0] MINIMIPS32_SW   = 8'h9A;

    localparam logic [4:0] EXC_NONE = 5'h10;
    localparam logic [4:0] EXC_ADEL = 5'h04;
    localparam logic [4:0] EXC_ADES = 5'h05;
    localparam logic [4:0] EXC_DBE  = 5'h07;

    typedef enum logic [1:0] {
        MS_IDLE  = 2'd0,
        MS_REQ   = 2'd1,
        MS_DONE  = 2'd2,
        MS_DRAIN = 2'd3
    } ms_state_t;

    function automatic logic is_load(input logic [7:0] op);
        return (op == MINIMIPS32_LB) || (op == MINIMIPS32_LBU) || (op == MINIMIPS32_LH) ||
               (op == MINIMIPS32_LHU) || (op == MINIMIPS32_LW);
    endfunction

    function automatic logic is_store(input logic [7:0] op);
        return (op == MINIMIPS32_SB) || (op == MINIMIPS32_SH) || (op == MINIMIPS32_SW);
    endfunction

    function automatic logic is_half(input logic [7:0] op);
        return (op == MINIMIPS32_LH) || (op == MINIMIPS32_LHU) || (op == MINIMIPS32_SH);
    endfunction

    function automatic logic is_word(input logic [7:0] op);
        return (op == MINIMIPS32_LW) || (op == MINIMIPS32_SW);
    endfunction

endpackage

// File: rtl/mem_lane_unit.sv
// Byte-lane logic: store enables and replication, little-endian load extraction and extension.
// Purely combinational, zero latency, no flow control.
module mem_lane_unit
    import mem_access_stage_pkg::*;
(
    input  logic [7:0]  i_aluop,
    input  logic [1:0]  i_addr_lo,
    input  logic [31:0] i_din,
    input  logic [31:0] i_rdata,
    output logic [3:0]  o_we,
    output logic [31:0] o_wdata,
    output logic [31:0] o_ldata
);

    logic [7:0]  w_byte;
    logic [15:0] w_half;

    always_comb begin
        o_we    = 4'b0000;
        o_wdata = i_din;
        case (i_aluop)
            MINIMIPS32_SB: begin
                o_we    = 4'b0001 << i_addr_lo;
                o_wdata = {4{i_din[7:0]}};
            end
            MINIMIPS32_SH: begin
                o_we    = i_addr_lo[1] ? 4'b1100 : 4'b0011;
                o_wdata = {2{i_din[15:0]}};
            end
            MINIMIPS32_SW: o_we = 4'b1111;
            default: ;
        endcase
    end

    always_comb begin
        w_byte = i_rdata[7:0];
        case (i_addr_lo)
            2'd1:    w_byte = i_rdata[15:8];
            2'd2:    w_byte = i_rdata[23:16];
            2'd3:    w_byte = i_rdata[31:24];
            default: w_byte = i_rdata[7:0];
        endcase
        w_half  = i_addr_lo[1] ? i_rdata[31:16] : i_rdata[15:0];
        o_ldata = i_rdata;
        case (i_aluop)
            MINIMIPS32_LB:  o_ldata = {{24{w_byte[7]}}, w_byte};
            MINIMIPS32_LBU: o_ldata = {24'h0, w_byte};
            MINIMIPS32_LH:  o_ldata = {{16{w_half[15]}}, w_half};
            MINIMIPS32_LHU: o_ldata = {16'h0, w_half};
            default: ;
        endcase
    end

endmodule

// File: rtl/mem_access_stage.sv
// Memory-access stage: one bus access per load/store, minimum 3 cycles; others pass through at zero latency.
// Holds the pipeline via stallreq_mem from issue until the ack (or watchdog abort) has been captured.
module mem_access_stage
    import mem_access_stage_pkg::*;
#(
    parameter int WAIT_W = 8
) (
    input  logic        cpu_clk_50M,
    input  logic        cpu_rst,
    input  logic        mem_flush_i,
    input  logic [7:0]  mem_aluop_i,
    input  logic [4:0]  mem_wa_i,
    input  logic        mem_wreg_i,
    input  logic        mem_mreg_i,
    input  logic [31:0] mem_wd_i,
    input  logic [31:0] mem_din_i,
    input  logic        mem_whilo_i,
    input  logic [63:0] mem_hilo_i,
    input  logic [4:0]  mem_exccode_i,
    output logic        dm_req,
    output logic [3:0]  dm_we,
    output logic [31:0] dm_addr,
    output logic [31:0] dm_wdata,
    input  logic        dm_ack,
    input  logic [31:0] dm_rdata,
    output logic [4:0]  mem_wa_o,
    output logic        mem_wreg_o,
    output logic [31:0] mem_wd_o,
    output logic        mem_whilo_o,
    output logic [63:0] mem_hilo_o,
    output logic [4:0]  mem_exccode_o,
    output logic        mem2id_wreg,
    output logic [4:0]  mem2id_wa,
    output logic [31:0] mem2id_wd,
    output logic        mem2exe_whilo,
    output logic [63:0] mem2exe_hilo,
    output logic        stallreq_mem
);

    localparam logic [WAIT_W-1:0] WDOG_LAST = {{(WAIT_W-1){1'b1}}, 1'b0};

    ms_state_t         r_state, w_next;
    logic [WAIT_W-1:0] r_wdog;
    logic [31:0]       r_rdata_q;
    logic              r_flush_seen, r_dbe;
    logic              w_is_load, w_is_store, w_misalign, w_mem_op, w_start, w_timeout;
    logic              w_stall, w_done, w_drain, w_suppress;
    logic [3:0]        w_we;
    logic [31:0]       w_wdata, w_ldata;

    mem_lane_unit u_lane (
        .i_aluop   (mem_aluop_i),
        .i_addr_lo (mem_wd_i[1:0]),
        .i_din     (mem_din_i),
        .i_rdata   (r_rdata_q),
        .o_we      (w_we),
        .o_wdata   (w_wdata),
        .o_ldata   (w_ldata)
    );

    assign w_is_load  = is_load(mem_aluop_i);
    assign w_is_store = is_store(mem_aluop_i);
    assign w_misalign = (is_half(mem_aluop_i) && mem_wd_i[0]) ||
                        (is_word(mem_aluop_i) && (mem_wd_i[1:0] != 2'b00));
    assign w_mem_op   = (w_is_load || w_is_store) && (mem_exccode_i == EXC_NONE) && !w_misalign;
    assign w_start    = (r_state == MS_IDLE) && w_mem_op && !mem_flush_i;
    assign w_timeout  = (r_state == MS_REQ) && !dm_ack && (r_wdog == WDOG_LAST);
    assign w_done     = (r_state == MS_DONE);
    assign w_drain    = (r_state == MS_DRAIN);

    always_comb begin
        w_next  = r_state;
        w_stall = 1'b0;
        case (r_state)
            MS_IDLE: begin
                if (w_start) begin
                    w_next  = MS_REQ;
                    w_stall = 1'b1;
                end
            end
            MS_REQ: begin
                w_stall = 1'b1;
                if (dm_ack)
                    w_next = (r_flush_seen || mem_flush_i) ? MS_DRAIN : MS_DONE;
                else if (w_timeout)
                    w_next = MS_DONE;
            end
            default: w_next = MS_IDLE;
        endcase
    end

    always_ff @(posedge cpu_clk_50M) begin
        if (cpu_rst) begin
            r_state      <= MS_IDLE;
            dm_req       <= 1'b0;
            dm_we        <= 4'b0000;
            dm_addr      <= 32'h0;
            dm_wdata     <= 32'h0;
            r_rdata_q    <= 32'h0;
            r_wdog       <= '0;
            r_flush_seen <= 1'b0;
            r_dbe        <= 1'b0;
        end else begin
            r_state <= w_next;
            if (w_start) begin
                dm_req       <= 1'b1;
                dm_we        <= w_we;
                dm_addr      <= {mem_wd_i[31:2], 2'b00};
                dm_wdata     <= w_wdata;
                r_wdog       <= '0;
                r_flush_seen <= 1'b0;
                r_dbe        <= 1'b0;
            end else if (r_state == MS_REQ) begin
                // The bus cycle cannot be cancelled; a flush only decides where the result goes.
                if (mem_flush_i)
                    r_flush_seen <= 1'b1;
                if (dm_ack) begin
                    dm_req    <= 1'b0;
                    dm_we     <= 4'b0000;
                    r_rdata_q <= dm_rdata;
                end else if (w_timeout) begin
                    dm_req <= 1'b0;
                    dm_we  <= 4'b0000;
                    r_dbe  <= 1'b1;
                end else begin
                    r_wdog <= r_wdog + 1'b1;
                end
            end
        end
    end

    // A bus-error abort delivers no load data, so its register write is dropped too.
    assign w_suppress = w_misalign || w_is_store || w_stall || w_drain || mem_flush_i ||
                        (w_done && r_dbe);

    always_comb begin
        mem_wa_o      = 5'h0;
        mem_wreg_o    = 1'b0;
        mem_wd_o      = 32'h0;
        mem_whilo_o   = 1'b0;
        mem_hilo_o    = 64'h0;
        mem_exccode_o = 5'h0;
        if (!cpu_rst) begin
            mem_wa_o    = mem_wa_i;
            mem_wreg_o  = mem_wreg_i && !w_suppress;
            mem_wd_o    = (w_done && mem_mreg_i && !r_dbe) ? w_ldata : mem_wd_i;
            mem_whilo_o = mem_whilo_i && !(w_stall || w_drain || mem_flush_i);
            mem_hilo_o  = mem_hilo_i;
            if (mem_exccode_i != EXC_NONE)
                mem_exccode_o = mem_exccode_i;
            else if (w_misalign)
                mem_exccode_o = w_is_load ? EXC_ADEL : EXC_ADES;
            else if (w_done && r_dbe)
                mem_exccode_o = EXC_DBE;
            else
                mem_exccode_o = EXC_NONE;
        end
    end

    assign stallreq_mem  = w_stall && !cpu_rst;
    assign mem2id_wreg   = mem_wreg_o;
    assign mem2id_wa     = mem_wa_o;
    assign mem2id_wd     = mem_wd_o;
    assign mem2exe_whilo = mem_whilo_o;
    assign mem2exe_hilo  = mem_hilo_o;

endmodule
